mac_sequencer: RTL and testbench
================================

# mac_sequencer

Control block in front of `mac_matrix`. It accepts one command carrying a full MAC_WIDTH×MAC_WIDTH weight tile and loads it into the array using the `instr`/`weights_request` exchange. It then streams a burst of input vectors into `values_in1` and emits the matching `values_out1` results with a valid/last tag. It sits between the host-side buffers and the systolic array, and it is the only driver of the array's control and data inputs.

## Interface
- DATA_SIZE, 8, bits per operand.
- MAC_WIDTH, 8, array rows/columns.
- PIPE_LATENCY, 2*MAC_WIDTH, cycles from a vector on `values_in1` to its result on `values_out1`.
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- cmd_valid  input  1  weight-tile command offered.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_weights  input  MAC_WIDTH*MAC_WIDTH*DATA_SIZE  weight tile; cell (r,c) occupies slice [(r*MAC_WIDTH+c)*DATA_SIZE +: DATA_SIZE].
- in_valid  input  1  input vector offered.
- in_ready  output  1  vector accepted this cycle.
- in_data  input  MAC_WIDTH*DATA_SIZE  input vector.
- in_last  input  1  final vector of the burst.
- out_valid  output  1  result vector present.
- out_data  output  2*MAC_WIDTH*DATA_SIZE  result vector, taken from `values_out1`.
- out_last  output  1  result belongs to the last input.
- done  output  1  one-cycle pulse when the burst has fully drained.
- instr  output  1  to `mac_matrix`.
- weights_request  input  MAC_WIDTH*MAC_WIDTH  from `mac_matrix`.
- weights_data_in  output  MAC_WIDTH*MAC_WIDTH*DATA_SIZE  to `mac_matrix`.
- values_in1, values_in2  output  2*MAC_WIDTH*DATA_SIZE  to `mac_matrix`.
- values_out1  input  2*MAC_WIDTH*DATA_SIZE  from `mac_matrix`.

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, capture cmd_weights into the tile register and go to LOAD.
  - LOAD: instr=1; weights_data_in=tile register. Stay at least 1 cycle. Exit to STREAM on the first cycle after entry in which weights_request == 0.
  - STREAM: in_ready=1, instr=0. Each handshake drives the vector zero-extended into values_in1; the upper half is 0. A handshake with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. Wait until the valid shift register is empty, then pulse done and go to IDLE.
- When no handshake occurs, values_in1 is driven to 0; the array sees bubbles.
- values_in2 is always driven to 0.
- weights_data_in holds the tile register in every state. The tile register changes only when a command is captured in IDLE.
- Result tracking: a PIPE_LATENCY-deep shift register carries {valid,last} per accepted vector.
  - out_valid and out_last are the register's tail.
  - out_data samples values_out1 in the same cycle.
- Output has no backpressure; the consumer must accept every out_valid cycle.
- A command offered outside IDLE waits (cmd_ready=0); it is never dropped.
- in_valid outside STREAM is ignored; no vector is consumed.
- Reset at any point clears the FSM to IDLE and clears the shift register, tile register and all outputs.
  - In-flight results are discarded.
  - done is not pulsed.

## Timing
- Reset values:
  - cmd_ready=1.
  - in_ready, out_valid, out_last, done, instr = 0.
  - weights_data_in, values_in1, values_in2, out_data = 0.
- cmd handshake at cycle t: instr=1 from t+1.
- LOAD lasts max(1, cycles until weights_request==0).
- Vector accepted at cycle t: on values_in1 at t+1; out_valid at t+1+PIPE_LATENCY.
- done is asserted exactly one cycle after the last out_valid. IDLE (cmd_ready=1) resumes in the same cycle as done.
- Back-to-back vectors sustain 1 per cycle. A single-vector burst (in_last on the first vector) is legal.

## Configuration
- MAC_SEQ_SKEW_EN defined:
  - Row i of values_in1 is delayed i cycles through a staircase of registers (systolic input skew).
  - Column j of out_data is de-skewed by MAC_WIDTH-1-j cycles.
  - Effective latency = PIPE_LATENCY + MAC_WIDTH - 1; the valid shift register lengthens to match.
- Undefined: vectors are driven and sampled unskewed; latency = PIPE_LATENCY.

## Structure
- Shared package `tpu_pkg`:
  - DATA_SIZE and MAC_WIDTH constants.
  - FSM state enum (IDLE, LOAD, STREAM, DRAIN).
  - Derived width constants for tile, vector and result buses.
- One sub-module, `mac_skew_line`: a parameterised per-lane delay staircase. It is instantiated twice (input skew, output de-skew) only under MAC_SEQ_SKEW_EN.

## Test plan
- Reset mid-STREAM with 3 vectors in flight -> no out_valid afterwards; done never pulses; cmd_ready=1 the cycle after reset.
- Tile of all 1s, weights_request held nonzero 4 cycles after LOAD entry -> instr=1 for exactly 5 cycles; STREAM is entered the next cycle.
- 8 back-to-back vectors, in_last on the 8th -> 8 consecutive out_valid starting exactly PIPE_LATENCY+1 cycles after the first accept; out_last on the 8th only; done the cycle after.
- in_valid toggled 1,0,1,1 with in_last on the final vector -> out_valid pattern 1,0,1,1 with identical spacing; values_in1=0 during the gap.
- cmd_valid held high during DRAIN -> cmd_ready=0 until done; command captured in the done cycle and LOAD entered the next cycle.
- With MAC_SEQ_SKEW_EN: identity weights, vector 1..8 -> out_data lower lanes equal 1..8 aligned in one cycle, at latency PIPE_LATENCY+MAC_WIDTH.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants, FSM state encoding and result-tracking tag for the MAC sequencer.
// MAC_SEQ_SKEW_EN lengthens the result latency by the systolic skew staircase.
package tpu_pkg;

  localparam int DATA_SIZE    = 8;
  localparam int MAC_WIDTH    = 8;
  localparam int PIPE_LATENCY = 2 * MAC_WIDTH;

  localparam int TILE_W = MAC_WIDTH * MAC_WIDTH * DATA_SIZE;
  localparam int VEC_W  = MAC_WIDTH * DATA_SIZE;
  localparam int RES_W  = 2 * MAC_WIDTH * DATA_SIZE;
  localparam int REQ_W  = MAC_WIDTH * MAC_WIDTH;

`ifdef MAC_SEQ_SKEW_EN
  localparam int RESULT_LATENCY = PIPE_LATENCY + MAC_WIDTH - 1;
`else
  localparam int RESULT_LATENCY = PIPE_LATENCY;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic vld;
    logic last;
  } trk_t;

endpackage

// File: rtl/mac_skew_line.sv
// mac_skew_line: per-lane delay staircase; lane i is delayed i cycles, or LANES-1-i when DESCEND.
// Latency: 0..LANES-1 cycles per lane. No backpressure; data advances every cycle.
module mac_skew_line #(
  parameter int LANES   = 8,
  parameter int LANE_W  = 8,
  parameter bit DESCEND = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LANES*LANE_W-1:0]   lanes_in,
  output logic [LANES*LANE_W-1:0]   lanes_out
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int DEPTH = DESCEND ? (LANES - 1 - i) : i;

    if (DEPTH == 0) begin : g_wire
      assign lanes_out[i*LANE_W +: LANE_W] = lanes_in[i*LANE_W +: LANE_W];
    end else begin : g_pipe
      logic [DEPTH-1:0][LANE_W-1:0] stage;

      always_ff @(posedge clock) begin
        if (reset) begin
          stage <= '0;
        end else begin
          stage[0] <= lanes_in[i*LANE_W +: LANE_W];
          for (int k = 1; k < DEPTH; k++) begin
            stage[k] <= stage[k-1];
          end
        end
      end

      assign lanes_out[i*LANE_W +: LANE_W] = stage[DEPTH-1];
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: loads one weight tile into mac_matrix, streams a vector burst, tags results (skew staircase under MAC_SEQ_SKEW_EN).
// Latency: vector accept -> out_valid in PIPE_LATENCY+1 cycles (+MAC_WIDTH-1 with MAC_SEQ_SKEW_EN).
// Backpressure: cmd_ready/in_ready follow FSM state only; results carry no backpressure.
module mac_sequencer
  import tpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [TILE_W-1:0] cmd_weights,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  output logic [RES_W-1:0]  out_data,
  output logic              out_last,
  output logic              done,
  output logic              instr,
  input  logic [REQ_W-1:0]  weights_request,
  output logic [TILE_W-1:0] weights_data_in,
  output logic [RES_W-1:0]  values_in1,
  output logic [RES_W-1:0]  values_in2,
  input  logic [RES_W-1:0]  values_out1
);

  seq_state_t state, state_nxt;

  logic [TILE_W-1:0]               tile_q;
  logic [VEC_W-1:0]                vin_q;
  trk_t                            vin_trk;
  trk_t [RESULT_LATENCY-1:0]       trk_q;
  logic                            done_q, done_nxt;
  logic                            cmd_take, in_take, drain_empty;
  logic [VEC_W-1:0]                vin_drive;
  logic [RES_W-1:0]                res_aligned;

  assign cmd_take = cmd_valid && cmd_ready;
  assign in_take  = in_valid && in_ready;
  // Only the tail may still be occupied: it is the final result leaving this cycle.
  assign drain_empty = !vin_trk.vld && (trk_q[RESULT_LATENCY-2:0] == '0);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    instr     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = LOAD;
      end
      LOAD: begin
        instr = 1'b1;
        if (weights_request == '0) state_nxt = STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_empty) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      tile_q  <= '0;
      vin_q   <= '0;
      vin_trk <= '0;
      trk_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      if (cmd_take) tile_q <= cmd_weights;
      vin_q        <= in_take ? in_data : '0;
      vin_trk.vld  <= in_take;
      vin_trk.last <= in_take && in_last;
      trk_q        <= {trk_q[RESULT_LATENCY-2:0], vin_trk};
    end
  end

`ifdef MAC_SEQ_SKEW_EN
  mac_skew_line #(
    .LANES  (MAC_WIDTH),
    .LANE_W (DATA_SIZE),
    .DESCEND(1'b0)
  ) u_in_skew (
    .clock    (clock),
    .reset    (reset),
    .lanes_in (vin_q),
    .lanes_out(vin_drive)
  );

  mac_skew_line #(
    .LANES  (MAC_WIDTH),
    .LANE_W (2 * DATA_SIZE),
    .DESCEND(1'b1)
  ) u_out_deskew (
    .clock    (clock),
    .reset    (reset),
    .lanes_in (values_out1),
    .lanes_out(res_aligned)
  );
`else
  assign vin_drive   = vin_q;
  assign res_aligned = values_out1;
`endif

  assign values_in1      = {{(RES_W-VEC_W){1'b0}}, vin_drive};
  assign values_in2      = '0;
  assign weights_data_in = tile_q;
  assign done            = done_q;
  assign out_valid       = trk_q[RESULT_LATENCY-1].vld;
  assign out_last        = trk_q[RESULT_LATENCY-1].last;
  // Gated so the bus reads zero whenever no tagged result is present.
  assign out_data        = out_valid ? res_aligned : '0;

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized scoreboard bench for mac_sequencer with a behavioural stand-in for mac_matrix.
module tb_mac_sequencer;
  import tpu_pkg::*;

`ifdef MAC_SEQ_SKEW_EN
  localparam int LAT = PIPE_LATENCY + MAC_WIDTH - 1;
`else
  localparam int LAT = PIPE_LATENCY;
`endif
  localparam int HIST = 64;

  typedef struct {
    int               cyc;
    logic [RES_W-1:0] data;
    logic             last;
  } exp_t;

  typedef struct {
    int               cyc;
    logic [VEC_W-1:0] data;
  } vin_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [TILE_W-1:0] cmd_weights = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [VEC_W-1:0]  in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic [RES_W-1:0]  out_data;
  logic              out_last;
  logic              done;
  logic              instr;
  logic [REQ_W-1:0]  weights_request = '0;
  logic [TILE_W-1:0] weights_data_in;
  logic [RES_W-1:0]  values_in1;
  logic [RES_W-1:0]  values_in2;
  logic [RES_W-1:0]  values_out1 = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_done = -1;
  int req_hold = 0;
  int load_cnt = 0;
  int instr_run = 0;
  logic [TILE_W-1:0] cur_tile = '0;
  logic [RES_W-1:0]  vhist [HIST];
  exp_t expq[$];
  vin_t vinq[$];
  exp_t mon_e;

  mac_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_weights    (cmd_weights),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .done           (done),
    .instr          (instr),
    .weights_request(weights_request),
    .weights_data_in(weights_data_in),
    .values_in1     (values_in1),
    .values_in2     (values_in2),
    .values_out1    (values_out1)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_v(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Reference: y_j = sum_i W[i][j] * x_i, truncated to the result lane width.
  function automatic logic [RES_W-1:0] mat_vec(input logic [TILE_W-1:0] w, input logic [VEC_W-1:0] x);
    logic [RES_W-1:0]       r;
    logic [2*DATA_SIZE-1:0] acc;
    r = '0;
    for (int j = 0; j < MAC_WIDTH; j++) begin
      acc = '0;
      for (int i = 0; i < MAC_WIDTH; i++)
        acc = acc + (16'(w[(i*MAC_WIDTH+j)*DATA_SIZE +: DATA_SIZE]) * 16'(x[i*DATA_SIZE +: DATA_SIZE]));
      r[j*2*DATA_SIZE +: 2*DATA_SIZE] = acc;
    end
    return r;
  endfunction

  // Array stand-in: column j at cycle c sees row i as driven PIPE_LATENCY (+skew) cycles earlier.
  function automatic logic [RES_W-1:0] array_out(input int c, input logic [TILE_W-1:0] w);
    logic [RES_W-1:0]       r;
    logic [RES_W-1:0]       v;
    logic [2*DATA_SIZE-1:0] acc;
    int src;
    r = '0;
    for (int j = 0; j < MAC_WIDTH; j++) begin
      acc = '0;
      for (int i = 0; i < MAC_WIDTH; i++) begin
        src = c - PIPE_LATENCY;
`ifdef MAC_SEQ_SKEW_EN
        src = src - j + i;
`endif
        if (src >= 0) begin
          v = vhist[src % HIST];
          acc = acc + (16'(w[(i*MAC_WIDTH+j)*DATA_SIZE +: DATA_SIZE]) * 16'(v[i*DATA_SIZE +: DATA_SIZE]));
        end
      end
      r[j*2*DATA_SIZE +: 2*DATA_SIZE] = acc;
    end
    return r;
  endfunction

  function automatic logic [TILE_W-1:0] rand_tile();
    logic [TILE_W-1:0] t;
    for (int k = 0; k < TILE_W/32; k++) t[k*32 +: 32] = $urandom;
    return t;
  endfunction

  always @(negedge clock) vhist[cyc % HIST] = values_in1;

  always @(posedge clock) begin
    #1;
    values_out1 = array_out(cyc, weights_data_in);
    if (instr) begin
      weights_request = (load_cnt < req_hold) ? {$urandom, $urandom | 32'd1} : '0;
      load_cnt++;
    end else begin
      weights_request = '0;
      load_cnt = 0;
    end
  end

  // Monitor: pops the scoreboard on every out_valid and checks done / LOAD timing.
  always @(negedge clock) begin
    logic [RES_W-1:0] exp_v;
    if (!reset) begin
      if (out_valid) begin
        chk_i("out_valid_expected", int'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          mon_e = expq.pop_front();
          chk_i("out_cycle", cyc, mon_e.cyc);
          chk_v("out_data", out_data, mon_e.data);
          chk_i("out_last", int'(out_last), int'(mon_e.last));
          if (mon_e.last) exp_done = cyc + 1;
        end
      end
      if (done) begin
        chk_i("done_cycle", cyc, exp_done);
        exp_done = -1;
      end else if (exp_done >= 0 && cyc > exp_done) begin
        note_fail("done_missing");
        exp_done = -1;
      end
      if (instr) instr_run++;
      else if (instr_run > 0) begin
        chk_i("instr_len", instr_run, req_hold + 1);
        chk_i("stream_after_load", int'(in_ready), 1);
        instr_run = 0;
      end
`ifndef MAC_SEQ_SKEW_EN
      exp_v = '0;
      if (vinq.size() != 0 && vinq[0].cyc == cyc) exp_v = {{(RES_W-VEC_W){1'b0}}, vinq.pop_front().data};
      chk_v("values_in1", values_in1, exp_v);
`endif
      chk_v("values_in2", values_in2, '0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals();
    chk_i("rst_cmd_ready", int'(cmd_ready), 1);
    chk_i("rst_in_ready", int'(in_ready), 0);
    chk_i("rst_out_valid", int'(out_valid), 0);
    chk_i("rst_out_last", int'(out_last), 0);
    chk_i("rst_done", int'(done), 0);
    chk_i("rst_instr", int'(instr), 0);
    chk_i("rst_weights_zero", int'(weights_data_in == '0), 1);
    chk_v("rst_values_in1", values_in1, '0);
    chk_v("rst_out_data", out_data, '0);
  endtask

  task automatic send_cmd(input logic [TILE_W-1:0] t, input int hold);
    int g = 0;
    req_hold    = hold;
    cmd_valid   = 1'b1;
    cmd_weights = t;
    @(negedge clock);
    while (!cmd_ready && g < 100) begin
      step();
      @(negedge clock);
      g++;
    end
    if (!cmd_ready) note_fail("cmd_timeout");
    cur_tile = t;
    step();
    cmd_valid   = 1'b0;
    cmd_weights = rand_tile();
    @(negedge clock);
    chk_i("instr_after_cmd", int'(instr), 1);
    step();
  endtask

  task automatic run_burst(input int n, input logic [31:0] pat, input int pat_len,
                           input int gap_pct, input bit final_last, input bit ramp);
    int sent = 0, idx = 0, g = 0;
    logic [VEC_W-1:0] rv;
    for (int i = 0; i < MAC_WIDTH; i++) rv[i*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(i + 1);
    while (sent < n && g < 500) begin
      in_valid = (idx < pat_len) ? pat[idx] : (int'($urandom_range(0, 99)) >= gap_pct);
      in_data  = ramp ? rv : {$urandom, $urandom};
      in_last  = final_last && (sent == n - 1);
      @(negedge clock);
      if (g == 0) chk_i("tile_hold", int'(weights_data_in == cur_tile), 1);
      if (in_valid && in_ready) begin
        expq.push_back('{cyc: cyc + 1 + LAT, data: mat_vec(cur_tile, in_data), last: in_last});
        vinq.push_back('{cyc: cyc + 1, data: in_data});
        sent++;
      end
      if (in_ready) idx++;
      step();
      g++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (sent < n) note_fail("burst_timeout");
  endtask

  task automatic wait_done(input int bound);
    int g = 0;
    in_valid = 1'($urandom);
    @(negedge clock);
    while (!done && g < bound) begin
      step();
      in_valid = 1'($urandom);
      in_data  = {$urandom, $urandom};
      @(negedge clock);
      g++;
    end
    in_valid = 1'b0;
    if (!done) note_fail("done_timeout");
    step();
  endtask

  task automatic drain_with_cmd(input logic [TILE_W-1:0] t, input int hold, input int bound);
    int g = 0;
    req_hold    = hold;
    cmd_valid   = 1'b1;
    cmd_weights = t;
    @(negedge clock);
    while (!done && g < bound) begin
      chk_i("cmd_ready_in_drain", int'(cmd_ready), 0);
      step();
      @(negedge clock);
      g++;
    end
    if (!done) note_fail("drain_done_timeout");
    chk_i("cmd_ready_at_done", int'(cmd_ready), 1);
    cur_tile = t;
    step();
    cmd_valid   = 1'b0;
    cmd_weights = rand_tile();
    @(negedge clock);
    chk_i("instr_after_drain_cmd", int'(instr), 1);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [TILE_W-1:0] t;
    for (int k = 0; k < HIST; k++) vhist[k] = '0;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals();
    step();

    // All-ones tile, request held 4 cycles, 8 back-to-back vectors.
    t = '0;
    for (int k = 0; k < MAC_WIDTH*MAC_WIDTH; k++) t[k*DATA_SIZE +: DATA_SIZE] = 8'd1;
    send_cmd(t, 4);
    run_burst(8, 32'hFF, 8, 0, 1'b1, 1'b0);
    wait_done(100);

    // Gap pattern 1,0,1,1 then a command held through DRAIN.
    send_cmd(rand_tile(), 0);
    run_burst(3, 32'b1101, 4, 0, 1'b1, 1'b0);
    drain_with_cmd(rand_tile(), 2, 100);
    run_burst(5, 32'h0, 0, 30, 1'b1, 1'b0);
    wait_done(100);

    // Single-vector burst.
    send_cmd(rand_tile(), 1);
    run_burst(1, 32'h1, 1, 0, 1'b1, 1'b0);
    wait_done(100);

    for (int k = 0; k < 6; k++) begin
      send_cmd(rand_tile(), int'($urandom_range(0, 5)));
      run_burst(int'($urandom_range(1, 10)), 32'h0, 0, int'($urandom_range(0, 50)), 1'b1, 1'b0);
      wait_done(100);
    end

    // Reset mid-STREAM with three vectors in flight.
    send_cmd(rand_tile(), 1);
    run_burst(3, 32'h7, 3, 0, 1'b0, 1'b0);
    reset = 1'b1;
    expq.delete();
    vinq.delete();
    exp_done = -1;
    instr_run = 0;
    step();
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals();
    step();
    repeat (40) step();

    // Identity tile with ramp vector 1..MAC_WIDTH.
    t = '0;
    for (int i = 0; i < MAC_WIDTH; i++) t[(i*MAC_WIDTH+i)*DATA_SIZE +: DATA_SIZE] = 8'd1;
    send_cmd(t, 0);
    run_burst(1, 32'h1, 1, 0, 1'b1, 1'b1);
    wait_done(100);

    repeat (30) step();
    chk_i("scoreboard_empty", int'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
